// File: rtl/fault_campaign_if.sv
// Handshake bundle between the fault-campaign controller and the injector / CUT comparison side.
// The controller takes the master modport; the injector/pattern side takes the slave modport.
interface fault_campaign_if #(
    parameter int OUT_BITS = 25,
    parameter int CNT_W    = 16
);
    logic                start;
    logic                FIL_END;
    logic [OUT_BITS-1:0] CUT_OP;
    logic [OUT_BITS-1:0] FF_OP;
    logic [OUT_BITS-1:0] OUT_MASK;
    logic                FIL_INC;
    logic                PAT_REQ;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    fault_cnt;
    logic [CNT_W-1:0]    det_cnt;
    logic                det_pulse;

    modport master (
        input  start, FIL_END, CUT_OP, FF_OP, OUT_MASK,
        output FIL_INC, PAT_REQ, busy, done, fault_cnt, det_cnt, det_pulse
    );

    modport slave (
        output start, FIL_END, CUT_OP, FF_OP, OUT_MASK,
        input  FIL_INC, PAT_REQ, busy, done, fault_cnt, det_cnt, det_pulse
    );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: injects each fault, applies patterns, compares faulty vs
// fault-free outputs after LAT cycles, and keeps saturating fault / detection counts.
module fault_campaign_ctrl #(
    parameter int OUT_BITS      = 25,
    parameter int PAT_PER_FAULT = 16,
    parameter int LAT           = 1,
    parameter int CNT_W         = 16,
    parameter int DROP          = 1
) (
    input  logic             clk,
    input  logic             rst,
    fault_campaign_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        INJECT,
        APPLY,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    localparam int               PIDX_W    = (PAT_PER_FAULT > 1) ? $clog2(PAT_PER_FAULT) : 1;
    localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(PAT_PER_FAULT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t             state, state_nxt;
    logic [PIDX_W-1:0]  pat_idx, pat_idx_nxt;
    logic [LAT-1:0]     vld, vld_shift;
    logic               detected, detected_nxt;
    logic [CNT_W-1:0]   fault_cnt, fault_cnt_nxt;
    logic [CNT_W-1:0]   det_cnt, det_cnt_nxt;
    logic               mismatch;
    logic               pat_req, fil_inc, det_pulse;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // The bit leaving the valid pipeline marks the cycle whose CUT_OP/FF_OP belong to a pattern.
    assign mismatch  = vld[LAT-1] & (|((bus.CUT_OP ^ bus.FF_OP) & bus.OUT_MASK));
    assign vld_shift = vld << 1;

    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves one unassigned.
        state_nxt     = state;
        pat_idx_nxt   = pat_idx;
        detected_nxt  = detected | mismatch;
        fault_cnt_nxt = fault_cnt;
        det_cnt_nxt   = det_cnt;
        pat_req       = 1'b0;
        fil_inc       = 1'b0;
        det_pulse     = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt     = INJECT;
                    fault_cnt_nxt = '0;
                    det_cnt_nxt   = '0;
                    detected_nxt  = 1'b0;
                end
            end
            INJECT: begin
                fil_inc     = 1'b1;
                pat_idx_nxt = '0;
                state_nxt   = APPLY;
            end
            APPLY: begin
                pat_req     = 1'b1;
                pat_idx_nxt = pat_idx + 1'b1;
                if (pat_idx == PIDX_LAST || (DROP != 0 && mismatch)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the entry exiting now was the last one in flight.
                if (vld_shift == '0) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                fault_cnt_nxt = sat_inc(fault_cnt);
                if (detected) begin
                    det_cnt_nxt = sat_inc(det_cnt);
                    det_pulse   = 1'b1;
                end
                detected_nxt = 1'b0;
                state_nxt    = bus.FIL_END ? DONE : INJECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst) begin
            state     <= IDLE;
            pat_idx   <= '0;
            vld       <= '0;
            detected  <= 1'b0;
            fault_cnt <= '0;
            det_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            pat_idx   <= pat_idx_nxt;
            vld       <= vld_shift | LAT'(pat_req);
            detected  <= detected_nxt;
            fault_cnt <= fault_cnt_nxt;
            det_cnt   <= det_cnt_nxt;
        end
    end

    assign bus.FIL_INC   = fil_inc;
    assign bus.PAT_REQ   = pat_req;
    assign bus.det_pulse = det_pulse;
    assign bus.busy      = (state == INJECT) || (state == APPLY) || (state == DRAIN) || (state == NEXT);
    assign bus.done      = (state == DONE);
    assign bus.fault_cnt = fault_cnt;
    assign bus.det_cnt   = det_cnt;
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: three configurations run the same campaigns against a behavioural
// injector/CUT with latency, and results are compared with per-fault arithmetic expectations.
`timescale 1ns/1ps
module tb_fault_campaign_ctrl;
    localparam int OUT_BITS = 25;
    localparam int PPF      = 4;
    localparam int NCFG     = 3;
    localparam int MAXF     = 8;

    function automatic int cfg_lat(input int g);  return (g == 2) ? 2 : 1;  endfunction
    function automatic int cfg_drop(input int g); return (g == 1) ? 0 : 1;  endfunction
    function automatic int cfg_cntw(input int g); return (g == 2) ? 2 : 16; endfunction

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic clr;
    int   num_faults;
    logic [OUT_BITS-1:0] out_mask;
    logic [OUT_BITS-1:0] err_tab [MAXF][PPF];

    logic [15:0] obs_fault [NCFG];
    logic [15:0] obs_det   [NCFG];
    logic        obs_busy  [NCFG];
    logic        obs_done  [NCFG];
    logic        obs_pat   [NCFG];
    logic        obs_inc   [NCFG];
    logic        obs_pulse [NCFG];
    logic [31:0] mon_busy  [NCFG];
    logic [31:0] mon_pats  [NCFG];
    logic [31:0] mon_pat0  [NCFG];
    logic [31:0] mon_inc   [NCFG];
    logic [31:0] mon_pulse [NCFG];
    logic [31:0] mon_viol  [NCFG];

    int exp_fault [NCFG];
    int exp_det   [NCFG];
    int exp_busy  [NCFG];
    int exp_pats  [NCFG];
    int exp_pat0  [NCFG];
    int exp_inc   [NCFG];
    int exp_pulse [NCFG];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int L = cfg_lat(g);
        localparam int W = cfg_cntw(g);

        fault_campaign_if #(.OUT_BITS(OUT_BITS), .CNT_W(W)) u_if ();

        fault_campaign_ctrl #(
            .OUT_BITS(OUT_BITS), .PAT_PER_FAULT(PPF), .LAT(L), .CNT_W(W), .DROP(cfg_drop(g))
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(u_if)
        );

        int fault_idx;
        int pat_idx;
        int d_f [L];
        int d_p [L];
        logic d_v [L];
        logic [OUT_BITS-1:0] ff_val, noise;
        logic [31:0] busy_cnt, pats, pat0, incs, pulses, viol;

        assign u_if.start    = start;
        assign u_if.FIL_END  = (fault_idx == num_faults - 1);
        assign u_if.OUT_MASK = out_mask;
        assign u_if.FF_OP    = ff_val;

        // Outside a valid response window the CUT output is garbage that must be ignored.
        always_comb begin
            u_if.CUT_OP = ff_val ^ noise;
            if (d_v[L-1]) begin
                u_if.CUT_OP = ff_val;
                if (d_f[L-1] >= 0 && d_f[L-1] < MAXF && d_p[L-1] >= 0 && d_p[L-1] < PPF)
                    u_if.CUT_OP = ff_val ^ err_tab[d_f[L-1]][d_p[L-1]];
            end
        end

        always @(posedge clk) begin
            ff_val <= OUT_BITS'($urandom);
            noise  <= OUT_BITS'($urandom);
            if (clr) begin
                fault_idx <= -1;
                pat_idx   <= 0;
                for (int k = 0; k < L; k++) d_v[k] <= 1'b0;
            end else begin
                if (u_if.FIL_INC) begin
                    fault_idx <= fault_idx + 1;
                    pat_idx   <= 0;
                end else if (u_if.PAT_REQ) begin
                    pat_idx <= pat_idx + 1;
                end
                d_v[0] <= u_if.PAT_REQ;
                d_f[0] <= fault_idx;
                d_p[0] <= pat_idx;
                for (int k = 1; k < L; k++) begin
                    d_v[k] <= d_v[k-1];
                    d_f[k] <= d_f[k-1];
                    d_p[k] <= d_p[k-1];
                end
            end
        end

        always @(negedge clk) begin
            if (clr) begin
                busy_cnt <= 0; pats <= 0; pat0 <= 0; incs <= 0; pulses <= 0; viol <= 0;
            end else begin
                if (u_if.busy) busy_cnt <= busy_cnt + 1;
                if (u_if.PAT_REQ) begin
                    pats <= pats + 1;
                    if (fault_idx == 0) pat0 <= pat0 + 1;
                end
                if (u_if.FIL_INC) incs <= incs + 1;
                if (u_if.det_pulse) pulses <= pulses + 1;
                if (!u_if.busy && (u_if.PAT_REQ || u_if.FIL_INC || u_if.det_pulse)) viol <= viol + 1;
            end
        end

        assign obs_fault[g] = 16'(u_if.fault_cnt);
        assign obs_det[g]   = 16'(u_if.det_cnt);
        assign obs_busy[g]  = u_if.busy;
        assign obs_done[g]  = u_if.done;
        assign obs_pat[g]   = u_if.PAT_REQ;
        assign obs_inc[g]   = u_if.FIL_INC;
        assign obs_pulse[g] = u_if.det_pulse;
        assign mon_busy[g]  = busy_cnt;
        assign mon_pats[g]  = pats;
        assign mon_pat0[g]  = pat0;
        assign mon_inc[g]   = incs;
        assign mon_pulse[g] = pulses;
        assign mon_viol[g]  = viol;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per fault: the first unmasked mismatching pattern decides detection; with dropping, patterns
    // keep issuing until that mismatch is seen LAT cycles later. Each fault costs 2 + applied + LAT.
    function automatic void model(input int g);
        int lat, maxc, det, first, applied, busy, pats;
        lat  = cfg_lat(g);
        maxc = (1 << cfg_cntw(g)) - 1;
        det  = 0;
        busy = 0;
        pats = 0;
        exp_pat0[g] = 0;
        for (int f = 0; f < num_faults; f++) begin
            first = -1;
            for (int p = PPF - 1; p >= 0; p--)
                if ((err_tab[f][p] & out_mask) != '0) first = p;
            applied = PPF;
            if (cfg_drop(g) != 0 && first >= 0 && first + lat + 1 < PPF) applied = first + lat + 1;
            busy += 2 + applied + lat;
            pats += applied;
            if (f == 0) exp_pat0[g] = applied;
            if (first >= 0) det++;
        end
        exp_fault[g] = (num_faults > maxc) ? maxc : num_faults;
        exp_det[g]   = (det > maxc) ? maxc : det;
        exp_busy[g]  = busy;
        exp_pats[g]  = pats;
        exp_inc[g]   = num_faults;
        exp_pulse[g] = det;
    endfunction

    task automatic clear_errs();
        for (int f = 0; f < MAXF; f++)
            for (int p = 0; p < PPF; p++) err_tab[f][p] = '0;
    endtask

    task automatic run_campaign(input string tag, input int nf, input bit mid_start);
        bit all_done;
        num_faults = nf;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        all_done = 1'b0;
        for (int c = 0; c < 600 && !all_done; c++) begin
            @(posedge clk); #1 start = mid_start && (c == 3);
            @(negedge clk);
            all_done = obs_done[0] && obs_done[1] && obs_done[2];
        end
        start = 1'b0;
        check({tag, " completion"}, 64'(all_done), 64'd1);
        @(posedge clk); #1;
        for (int g = 0; g < NCFG; g++) begin
            model(g);
            check($sformatf("%s/cfg%0d fault_cnt", tag, g), 64'(obs_fault[g]), 64'(exp_fault[g]));
            check($sformatf("%s/cfg%0d det_cnt", tag, g), 64'(obs_det[g]), 64'(exp_det[g]));
            check($sformatf("%s/cfg%0d done_busy", tag, g), {62'd0, obs_done[g], obs_busy[g]}, 64'd2);
            check($sformatf("%s/cfg%0d busy_cycles", tag, g), 64'(mon_busy[g]), 64'(exp_busy[g]));
            check($sformatf("%s/cfg%0d pat_req_total", tag, g), 64'(mon_pats[g]), 64'(exp_pats[g]));
            check($sformatf("%s/cfg%0d pat_req_fault1", tag, g), 64'(mon_pat0[g]), 64'(exp_pat0[g]));
            check($sformatf("%s/cfg%0d fil_inc", tag, g), 64'(mon_inc[g]), 64'(exp_inc[g]));
            check($sformatf("%s/cfg%0d det_pulse", tag, g), 64'(mon_pulse[g]), 64'(exp_pulse[g]));
            check($sformatf("%s/cfg%0d idle_pulses", tag, g), 64'(mon_viol[g]), 64'd0);
        end
    endtask

    function automatic logic [63:0] out_vec(input int g);
        return {27'd0, obs_busy[g], obs_done[g], obs_pat[g], obs_inc[g], obs_pulse[g],
                obs_fault[g], obs_det[g]};
    endfunction

    initial begin
        bit found;
        int nf;
        logic [OUT_BITS-1:0] v;

        rst        = 1'b0;
        start      = 1'b0;
        clr        = 1'b1;
        num_faults = 1;
        out_mask   = '1;
        clear_errs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) check($sformatf("reset/cfg%0d outputs", g), out_vec(g), 64'd0);
        @(posedge clk); #1 rst = 1'b1; clr = 1'b0;

        // Fault-free run: 3 faults, no detections.
        run_campaign("clean", 3, 1'b0);

        // Single unmasked mismatch on pattern 0 of the first fault.
        err_tab[0][0] = 25'h0000001;
        run_campaign("drop", 3, 1'b0);

        // Mismatch only on a masked-off bit is never a detection.
        clear_errs();
        out_mask = ~(25'd1 << 5);
        for (int p = 0; p < PPF; p++) err_tab[1][p] = 25'd1 << 5;
        run_campaign("masked", 3, 1'b0);

        // Every fault detected: the 2-bit counters must stop at 3.
        out_mask = '1;
        for (int f = 0; f < MAXF; f++)
            for (int p = 0; p < PPF; p++) err_tab[f][p] = 25'h1000000 >> f;
        run_campaign("saturate", 5, 1'b0);

        // Reset in the middle of the second fault's pattern phase, then no resume.
        clear_errs();
        num_faults = 4;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            found = (obs_fault[0] == 16'd1) && obs_pat[0];
        end
        check("rst_mid reached", 64'(found), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) check($sformatf("rst_mid/cfg%0d outputs", g), out_vec(g), 64'd0);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        for (int g = 0; g < NCFG; g++) check($sformatf("no_resume/cfg%0d outputs", g), out_vec(g), 64'd0);
        run_campaign("after_rst", 2, 1'b0);

        // Randomised campaigns; odd ones also pulse start while busy.
        for (int r = 0; r < 8; r++) begin
            nf       = $urandom_range(1, MAXF);
            out_mask = OUT_BITS'($urandom) | 25'h1;
            for (int f = 0; f < MAXF; f++)
                for (int p = 0; p < PPF; p++) begin
                    v = OUT_BITS'($urandom);
                    case ($urandom_range(0, 5))
                        0:       err_tab[f][p] = v & out_mask;
                        1:       err_tab[f][p] = v & ~out_mask;
                        default: err_tab[f][p] = '0;
                    endcase
                end
            run_campaign($sformatf("rand%0d", r), nf, (nf >= 3) && (r % 2 == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fault_campaign_ctrl.md
FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

Interface
REQ-001 Parameter OUT_BITS, default 25, width of compared CUT outputs.
REQ-002 Parameter PAT_PER_FAULT, default 16, patterns applied per injected fault (>=1).
REQ-003 Parameter LAT, default 1, cycles from PAT_REQ to comparable CUT_OP/FF_OP (>=1).
REQ-004 Parameter CNT_W, default 16, width of fault and detection counters.
REQ-005 Parameter DROP, default 1, fault dropping: 1 = stop patterns on first detection, 0 = always apply all patterns.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  campaign start request, sampled in IDLE and DONE only.
REQ-009 FIL_END  input  1  high when the fault injection logic holds its last fault.
REQ-010 CUT_OP  input  OUT_BITS  faulty CUT output.
REQ-011 FF_OP  input  OUT_BITS  fault-free CUT output.
REQ-012 OUT_MASK  input  OUT_BITS  1 = bit compared, 0 = bit ignored; quasi-static during a campaign.
REQ-013 FIL_INC  output  1  one-cycle pulse advancing the injector to the next fault.
REQ-014 PAT_REQ  output  1  pattern generator advances and TEST_IP is applied this cycle.
REQ-015 busy  output  1  campaign in progress.
REQ-016 done  output  1  campaign complete, held until next start or reset.
REQ-017 fault_cnt  output  CNT_W  faults evaluated.
REQ-018 det_cnt  output  CNT_W  faults detected.
REQ-019 det_pulse  output  1  one-cycle pulse when a fault concludes as detected.

Function
REQ-020 FSM states SHALL be IDLE, INJECT, APPLY, DRAIN, NEXT, DONE.
REQ-021 IDLE/DONE + start=1: clear fault_cnt, det_cnt, detected flag; go INJECT next cycle.
REQ-022 INJECT lasts exactly one cycle with FIL_INC=1, then APPLY.
REQ-023 APPLY: PAT_REQ=1 every cycle; pattern index counts 0..PAT_PER_FAULT-1; after the last index, go DRAIN.
REQ-024 A LAT-deep valid pipeline SHALL track each PAT_REQ; comparison uses CUT_OP/FF_OP in the cycle its valid bit exits.
REQ-025 Mismatch = OR-reduce((CUT_OP XOR FF_OP) AND OUT_MASK), qualified by the exiting valid bit; mismatch sets the per-fault detected flag.
REQ-026 DROP=1: a qualified mismatch in APPLY forces PAT_REQ=0 from the next cycle and transitions to DRAIN.
REQ-027 DRAIN: PAT_REQ=0; stay until the valid pipeline is empty; mismatches still set detected; then NEXT.
REQ-028 NEXT lasts one cycle: fault_cnt+1; det_cnt+1 and det_pulse=1 if detected; detected cleared.
REQ-029 In NEXT, FIL_END=1 -> DONE, else INJECT.
REQ-030 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-031 busy=1 in INJECT, APPLY, DRAIN, NEXT; done=1 only in DONE.
REQ-032 start while busy SHALL be ignored.
REQ-033 FIL_INC, PAT_REQ, det_pulse SHALL never be high in IDLE or DONE.
REQ-034 Fault-free timing: 1 + PAT_PER_FAULT + LAT + 1 cycles per fault.

Reset
REQ-035 rst=0 at any clock edge, including mid-campaign: state IDLE, pipeline cleared, all outputs 0, counters 0.
REQ-036 Campaign aborted by reset SHALL NOT resume; new start required.

Verification
REQ-037 PAT_PER_FAULT=4, LAT=1, no mismatches, FIL_END high at 3rd fault -> 21 busy cycles, 12 PAT_REQ, 3 FIL_INC, fault_cnt=3, det_cnt=0, done=1.
REQ-038 DROP=1, LAT=1, mismatch on pattern 0 of fault 1 only -> fault 1 gets 2 PAT_REQ, one det_pulse, det_cnt=1.
REQ-039 DROP=0, same stimulus -> fault 1 gets all 4 PAT_REQ, det_cnt=1.
REQ-040 Mismatch only on bit 5, OUT_MASK[5]=0 -> no detection, det_cnt=0.
REQ-041 CNT_W=2, 5 faults all detected -> fault_cnt=3, det_cnt=3 (saturated).
REQ-042 rst=0 during APPLY of fault 2 -> next cycle all outputs 0, state IDLE; start afterwards restarts from fault_cnt=0.
